// File: rtl/sentrycontrol_trace_jumppacker.sv
// ============================================================================
// Module : sentrycontrol_trace_jumppacker
// Brief  : Packs up to two committed instructions per cycle, in program order,
//          into 4-slot jump-result packets for the trace FIFO.
//          Optional counters enabled by JUMP_PACKER_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef SENTRY_WIDTH
`define SENTRY_WIDTH 4
`endif

package sentrycontrol_trace_jumppacker_pkg;
    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic  jump_flag;
        addr_t result;
    } jump_result_s;

    typedef struct packed {
        jump_result_s jump_result3;
        jump_result_s jump_result2;
        jump_result_s jump_result1;
        jump_result_s jump_result0;
    } quad_jump_result_s;
endpackage

module sentrycontrol_trace_jumppacker
    import sentrycontrol_trace_jumppacker_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        commit_valid,
    input  logic [1:0]        commit_jump,
    input  addr_t [1:0]       commit_result,
    output logic              commit_ready,
    input  logic              trace_full,
    output logic              trace_wr_en,
    output quad_jump_result_s trace_data
`ifdef JUMP_PACKER_STATS_EN
    ,
    output logic [31:0]       pkt_count,
    output logic [31:0]       jump_count,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int c_SLOTS = `SENTRY_WIDTH;

    if (COMMIT_WIDTH != 2) begin : g_bad_commit_width
        $error("sentrycontrol_trace_jumppacker: COMMIT_WIDTH must be 2");
    end
    if (c_SLOTS != 4) begin : g_bad_sentry_width
        $error("sentrycontrol_trace_jumppacker: SENTRY_WIDTH must be 4");
    end

    jump_result_s      r_buf [4];
    logic [1:0]        r_fill;
    quad_jump_result_s r_pkt;
    logic              r_pkt_valid;

    logic              w_ready;
    logic              w_wr_en;
    logic [1:0]        w_acc;
    logic [2:0]        w_n;
    logic [2:0]        w_sum;
    logic              w_complete;
    jump_result_s      w_first;
    jump_result_s      w_second;
    jump_result_s      w_slot [4];
    quad_jump_result_s w_pkt;

    assign w_ready      = !r_pkt_valid || !trace_full;
    assign w_wr_en      = r_pkt_valid && !trace_full && !rst;
    assign commit_ready = w_ready;
    assign trace_wr_en  = w_wr_en;
    assign trace_data   = r_pkt;

    always_comb begin
        w_acc      = commit_valid & {2{w_ready}};
        w_n        = {2'b00, w_acc[0]} + {2'b00, w_acc[1]};
        w_sum      = {1'b0, r_fill} + w_n;
        w_complete = w_sum[2];
        // Compaction: a lone lane-1 commit is treated as the oldest instruction.
        w_first    = w_acc[0] ? jump_result_s'{commit_jump[0], commit_result[0]}
                              : jump_result_s'{commit_jump[1], commit_result[1]};
        w_second   = jump_result_s'{commit_jump[1], commit_result[1]};
        // Slot image without wrap-around; an overflow instruction goes to slot 0 later.
        for (int i = 0; i < 4; i++) begin
            w_slot[i] = r_buf[i];
            if (w_n != 3'd0 && {1'b0, r_fill} == 3'(i)) begin
                w_slot[i] = w_first;
            end
            if (w_n == 3'd2 && ({1'b0, r_fill} + 3'd1) == 3'(i)) begin
                w_slot[i] = w_second;
            end
        end
        w_pkt.jump_result0 = w_slot[0];
        w_pkt.jump_result1 = w_slot[1];
        w_pkt.jump_result2 = w_slot[2];
        w_pkt.jump_result3 = w_slot[3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill      <= 2'd0;
            r_pkt       <= '0;
            r_pkt_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_fill <= w_sum[1:0];
            if (w_complete) begin
                r_pkt       <= w_pkt;
                r_pkt_valid <= 1'b1;
                r_buf[0]    <= w_second;
            end else begin
                if (w_wr_en) begin
                    r_pkt_valid <= 1'b0;
                end
                for (int i = 0; i < 4; i++) begin
                    r_buf[i] <= w_slot[i];
                end
            end
        end
    end

`ifdef JUMP_PACKER_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_jump_count;
    logic [31:0] r_stall_cycles;
    logic [31:0] w_jumps;

    assign w_jumps      = {31'd0, w_acc[0] & commit_jump[0]} + {31'd0, w_acc[1] & commit_jump[1]};
    assign pkt_count    = r_pkt_count;
    assign jump_count   = r_jump_count;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count    <= '0;
            r_jump_count   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_wr_en) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            r_jump_count <= r_jump_count + w_jumps;
            if (|commit_valid && !w_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sentrycontrol_trace_jumppacker.sv
// ============================================================================
// Module : tb_sentrycontrol_trace_jumppacker
// Brief  : Self-checking bench: vector table plus hand sequences, packet scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sentrycontrol_trace_jumppacker;
    import sentrycontrol_trace_jumppacker_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        commit_valid;
    logic [1:0]        commit_jump;
    addr_t [1:0]       commit_result;
    logic              commit_ready;
    logic              trace_full;
    logic              trace_wr_en;
    quad_jump_result_s trace_data;
`ifdef JUMP_PACKER_STATS_EN
    logic [31:0]       pkt_count;
    logic [31:0]       jump_count;
    logic [31:0]       stall_cycles;
`endif

    always #5 clk = ~clk;

    sentrycontrol_trace_jumppacker #(.COMMIT_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_jump   (commit_jump),
        .commit_result (commit_result),
        .commit_ready  (commit_ready),
        .trace_full    (trace_full),
        .trace_wr_en   (trace_wr_en),
        .trace_data    (trace_data)
`ifdef JUMP_PACKER_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .jump_count    (jump_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    typedef struct {
        logic [1:0] v;
        logic [1:0] j;
        addr_t      a0;
        addr_t      a1;
        logic       full;
        logic       rdy;
        logic       wr;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int m_pkts = 0;
    int m_jumps = 0;
    int m_stalls = 0;

    jump_result_s      part_q [$];
    quad_jump_result_s exp_q  [$];
    vec_t              tbl [11];

    function automatic void chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One clock cycle: drive, check combinational outputs, feed the scoreboard.
    task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] j,
                       input addr_t a0, input addr_t a1, input logic full,
                       input logic e_rdy, input logic e_wr);
        quad_jump_result_s p;
        rst              = r;
        commit_valid     = v;
        commit_jump      = j;
        commit_result[0] = a0;
        commit_result[1] = a1;
        trace_full       = full;
        #2;
        chk("commit_ready", commit_ready, e_rdy);
        chk("trace_wr_en", trace_wr_en, e_wr);
        if (trace_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL packet: got write %h expected no write", trace_data);
            end else begin
                p = exp_q.pop_front();
                if (trace_data !== p) begin
                    errors++;
                    $display("FAIL packet: got %h expected %h", trace_data, p);
                end
            end
        end
        if (!r) begin
            if (e_wr) m_pkts++;
            if (|v && !e_rdy) m_stalls++;
            if (e_rdy) begin
                for (int l = 0; l < 2; l++) begin
                    if (v[l]) begin
                        part_q.push_back(jump_result_s'{j[l], (l == 0) ? a0 : a1});
                        if (j[l]) m_jumps++;
                    end
                end
                if (part_q.size() >= 4) begin
                    p.jump_result0 = part_q.pop_front();
                    p.jump_result1 = part_q.pop_front();
                    p.jump_result2 = part_q.pop_front();
                    p.jump_result3 = part_q.pop_front();
                    exp_q.push_back(p);
                end
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            part_q.delete();
            exp_q.delete();
            m_pkts = 0;
            m_jumps = 0;
            m_stalls = 0;
        end
    endtask

    initial begin
        // Overflow sequence A; (B,C); (D,E); (F,G); (H,I) then compaction with f=3.
        tbl[0]  = '{2'b01, 2'b00, 32'h1000, 32'h0,    1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2'b11, 2'b10, 32'h1004, 32'h1008, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 2'b01, 32'h100c, 32'h2000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 2'b00, 32'h2004, 32'h2008, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{2'b11, 2'b11, 32'h200c, 32'h3000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 1'b1};
        tbl[6]  = '{2'b10, 2'b10, 32'h0,    32'h3004, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 2'b00, 32'h3008, 32'h0,    1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b10, 2'b01, 32'hdead, 32'h0300, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 1'b1};
        tbl[10] = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        commit_valid = 2'b00;
        commit_jump = 2'b00;
        commit_result[0] = '0;
        commit_result[1] = '0;
        trace_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_ready", commit_ready, 1'b1);
        chk("reset_wr_en", trace_wr_en, 1'b0);
        chk("reset_data", trace_data, '0);
        #1;

        // Single-lane fill
        cyc(0, 2'b01, 2'b00, 32'h100, 32'h0, 0, 1, 0);
        cyc(0, 2'b01, 2'b01, 32'h104, 32'h0, 0, 1, 0);
        cyc(0, 2'b01, 2'b00, 32'h200, 32'h0, 0, 1, 0);
        cyc(0, 2'b01, 2'b00, 32'h204, 32'h0, 0, 1, 0);
        cyc(0, 2'b00, 2'b00, 32'h0,   32'h0, 0, 1, 1);
        cyc(0, 2'b00, 2'b00, 32'h0,   32'h0, 0, 1, 0);

        for (int k = 0; k < 11; k++) begin
            cyc(0, tbl[k].v, tbl[k].j, tbl[k].a0, tbl[k].a1, tbl[k].full, tbl[k].rdy, tbl[k].wr);
        end

        // Backpressure: pending packet held while the FIFO is full
        cyc(0, 2'b11, 2'b00, 32'h4000, 32'h4004, 0, 1, 0);
        cyc(0, 2'b11, 2'b01, 32'h4008, 32'h400c, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 2'b11, 2'b11, 32'hbad0, 32'hbad4, 1, 0, 0);
        end
        cyc(0, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 1);
        cyc(0, 2'b11, 2'b10, 32'h5000, 32'h5004, 0, 1, 0);
        cyc(0, 2'b11, 2'b00, 32'h5008, 32'h500c, 0, 1, 0);
        cyc(0, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 1);
        cyc(0, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 0);

        // Back-to-back full-rate dual commits
        for (int k = 0; k < 8; k++) begin
            cyc(0, 2'b11, {1'b0, k[0]}, 32'h6000 + 32'(8 * k), 32'h6004 + 32'(8 * k),
                0, 1, (k >= 2 && k % 2 == 0));
        end
        cyc(0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 1, 1);
        cyc(0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 1, 0);
        chk("sb_empty", 132'(exp_q.size()), 132'd0);

`ifdef JUMP_PACKER_STATS_EN
        chk("pkt_count", pkt_count, 132'(m_pkts));
        chk("jump_count", jump_count, 132'(m_jumps));
        chk("stall_cycles", stall_cycles, 132'(m_stalls));
`endif

        // Reset with a pending packet and a partial assembly
        cyc(0, 2'b01, 2'b00, 32'h7000, 32'h0,    0, 1, 0);
        cyc(0, 2'b11, 2'b00, 32'h7004, 32'h7008, 0, 1, 0);
        cyc(0, 2'b11, 2'b00, 32'h700c, 32'h7010, 0, 1, 0);
        cyc(1, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 0);
        chk("data_after_rst", trace_data, '0);
        cyc(0, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 0);
        cyc(0, 2'b11, 2'b01, 32'h8000, 32'h8004, 0, 1, 0);
        cyc(0, 2'b11, 2'b00, 32'h8008, 32'h800c, 0, 1, 0);
        cyc(0, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 1);
        cyc(0, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 0);

`ifdef JUMP_PACKER_STATS_EN
        chk("pkt_count_post_rst", pkt_count, 132'(m_pkts));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
